// File: rtl/sum_frame_accum_if.sv
// Stream bundle for the frame accumulator: the adder result input, the flush
// control, and the ready/valid drained frame-sum output.
interface sum_frame_accum_if #(
   parameter int W = 12,
   parameter int N = 4
);
   localparam int OW = W + $clog2(N);

   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          clear;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_sum;
   logic          overflow;
   logic          busy;

   modport master (
      output in_valid, in_data, clear, out_ready,
      input  out_valid, out_sum, overflow, busy
   );

   modport slave (
      input  in_valid, in_data, clear, out_ready,
      output out_valid, out_sum, overflow, busy
   );
endinterface

// File: rtl/sum_frame_accum.sv
// Sums every N consecutive adder results into a frame sum and queues the sums
// in a small FWFT FIFO drained by ready/valid; full-FIFO frames are dropped.
module sum_frame_accum #(
   parameter int W     = 12,
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   sum_frame_accum_if.slave  bus
);
   localparam int OW = W + $clog2(N);
   localparam int CW = $clog2(N);
   localparam int PW = $clog2(DEPTH);

   logic [OW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic          out_valid_q, out_valid_d;
   logic          overflow_q, overflow_d;
   logic [OW-1:0] mem_q [DEPTH];

   logic [OW-1:0] frame_sum;
   logic          frame_done;
   logic          full;
   logic          pop;
   logic          push;

   // NOTE: every signal gets a default before any branch, so no latch is inferred.
   always_comb begin
      frame_sum   = acc_q + OW'(bus.in_data);
      frame_done  = bus.in_valid && (cnt_q == CW'(N - 1));
      full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      pop         = out_valid_q && bus.out_ready && !bus.clear;
      // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
      push        = frame_done && !bus.clear && (!full || pop);

      acc_d       = acc_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;

      if (bus.clear) begin
         acc_d      = '0;
         cnt_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
         if (push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
         if (frame_done && !push) overflow_d = 1'b1;
         if (bus.in_valid) begin
            if (frame_done) begin
               acc_d = '0;
               cnt_d = '0;
            end else begin
               acc_d = frame_sum;
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      out_valid_d = (wr_ptr_d != rd_ptr_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   // NOTE: storage is reset only because out_sum must read 0 during reset; clear leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q[PW-1:0]] <= frame_sum;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = mem_q[rd_ptr_q[PW-1:0]];
   assign bus.overflow  = overflow_q;
   assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_sum_frame_accum.sv
// Self-checking bench for sum_frame_accum: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_sum_frame_accum;
   localparam int W     = 12;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int MAXD  = (1 << W) - 1;

   logic clk;
   logic rst_n;

   sum_frame_accum_if #(.W(W), .N(N)) bus ();

   sum_frame_accum #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   // Reference model: frame progress as plain integers, FIFO as a queue.
   int m_acc;
   int m_cnt;
   int m_q[$];
   bit m_ovf;

   typedef struct {
      bit v;
      int d;
      bit rdy;
      bit e_valid;
      int e_sum;
      bit e_busy;
      bit e_ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0;
      m_cnt = 0;
      m_q.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_update(input bit v, input int d, input bit clr, input bit rdy);
      bit popped;
      if (clr) begin
         model_reset();
      end else begin
         popped = (m_q.size() != 0) && rdy;
         if (popped) void'(m_q.pop_front());
         if (v) begin
            if (m_cnt == N - 1) begin
               if (m_q.size() < DEPTH) m_q.push_back(m_acc + d);
               else m_ovf = 1'b1;
               m_acc = 0;
               m_cnt = 0;
            end else begin
               m_acc += d;
               m_cnt++;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_q.size() != 0));
      check({tag, ".busy"}, 32'(bus.busy), 32'(m_cnt != 0));
      check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
      if (m_q.size() != 0) check({tag, ".out_sum"}, 32'(bus.out_sum), 32'(m_q[0]));
   endtask

   // One clock: drive inputs just after an edge, advance the model, compare after the next edge.
   task automatic step(input bit v, input int d, input bit clr, input bit rdy);
      bus.in_valid  = v;
      bus.in_data   = W'(d);
      bus.clear     = clr;
      bus.out_ready = rdy;
      @(posedge clk);
      model_update(v, d, clr, rdy);
      #1;
      check_model("model");
   endtask

   task automatic frame(input int val, input bit rdy);
      for (int j = 0; j < N; j++) step(1'b1, val, 1'b0, rdy);
   endtask

   vec_t vecs[$];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      model_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b0;

      // Test 1 and 2 as a vector table: {v, d, rdy, e_valid, e_sum, e_busy, e_ovf}.
      vecs.push_back('{1, 1,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 2,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 3,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 4,    1, 1, 10,    0, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     0, 0});
      vecs.push_back('{1, 4095, 1, 0, 0,     1, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 4095, 1, 0, 0,     1, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     1, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 4095, 1, 0, 0,     1, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     1, 0});
      vecs.push_back('{1, 4095, 1, 1, 16380, 0, 0});
      vecs.push_back('{0, 0,    1, 0, 0,     0, 0});

      #12;
      check("reset.out_valid", 32'(bus.out_valid), 32'd0);
      check("reset.out_sum", 32'(bus.out_sum), 32'd0);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.overflow", 32'(bus.overflow), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].d, 1'b0, vecs[i].rdy);
         check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
         check($sformatf("vec%0d.overflow", i), 32'(bus.overflow), 32'(vecs[i].e_ovf));
         if (vecs[i].e_valid)
            check($sformatf("vec%0d.out_sum", i), 32'(bus.out_sum), 32'(vecs[i].e_sum));
      end

      // Test 3: stalled consumer, fifth frame dropped, then drain in order.
      for (int k = 1; k <= 5; k++) begin
         frame(k, 1'b0);
         if (k == 4) begin
            check("t3.full_valid", 32'(bus.out_valid), 32'd1);
            check("t3.full_ovf", 32'(bus.overflow), 32'd0);
         end
      end
      check("t3.drop_ovf", 32'(bus.overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         check("t3.drain_sum", 32'(bus.out_sum), 32'(4 * (i + 1)));
         step(1'b0, 0, 1'b0, 1'b1);
      end
      check("t3.empty", 32'(bus.out_valid), 32'd0);
      check("t3.ovf_sticky", 32'(bus.overflow), 32'd1);

      // Test 4: frame completes on a full FIFO while the head pops.
      step(1'b0, 0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) frame(k, 1'b0);
      for (int j = 0; j < N - 1; j++) step(1'b1, 5, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b1);
      check("t4.ovf", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         check("t4.drain_sum", 32'(bus.out_sum), 32'(8 + 4 * i));
         step(1'b0, 0, 1'b0, 1'b1);
      end
      check("t4.empty", 32'(bus.out_valid), 32'd0);

      // Test 5: clear with a colliding sample mid-frame.
      step(1'b0, 0, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) frame(k, 1'b0);
      step(1'b1, 1, 1'b0, 1'b0);
      step(1'b1, 1, 1'b0, 1'b0);
      check("t5.pre_busy", 32'(bus.busy), 32'd1);
      step(1'b1, 7, 1'b1, 1'b1);
      check("t5.valid", 32'(bus.out_valid), 32'd0);
      check("t5.ovf", 32'(bus.overflow), 32'd0);
      check("t5.busy", 32'(bus.busy), 32'd0);
      frame(1, 1'b0);
      check("t5.sum_valid", 32'(bus.out_valid), 32'd1);
      check("t5.sum", 32'(bus.out_sum), 32'd4);

      // Test 6: asynchronous reset mid-frame with two queued frames.
      step(1'b0, 0, 1'b1, 1'b0);
      frame(2, 1'b0);
      frame(3, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #2 rst_n = 1'b0;
      #1;
      check("t6.rst_valid", 32'(bus.out_valid), 32'd0);
      check("t6.rst_sum", 32'(bus.out_sum), 32'd0);
      check("t6.rst_busy", 32'(bus.busy), 32'd0);
      check("t6.rst_ovf", 32'(bus.overflow), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      frame(5, 1'b0);
      check("t6.sum_valid", 32'(bus.out_valid), 32'd1);
      check("t6.sum", 32'(bus.out_sum), 32'd20);
      step(1'b0, 0, 1'b0, 1'b1);
      check("t6.only_entry", 32'(bus.out_valid), 32'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 9) < 7,
              int'($urandom_range(0, MAXD)),
              $urandom_range(0, 59) == 0,
              $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
